// File: rtl/rtr_out_arbiter_if.sv
// Request/transfer bundle between the input-side requesters, the output
// arbiter and the output FIFO. The arbiter side uses the master modport.
interface rtr_out_arbiter_if #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned pckg_sz = 40
);
    logic                        en;
    logic [NUM_IN-1:0]           req;
    logic [NUM_IN*pckg_sz-1:0]   data_in;
    logic                        out_full;
    logic [NUM_IN-1:0]           pop;
    logic                        push;
    logic [pckg_sz-1:0]          data_out;

    modport master (
        input  en, req, data_in, out_full,
        output pop, push, data_out
    );

    modport slave (
        output en, req, data_in, out_full,
        input  pop, push, data_out
    );
endinterface

// File: rtl/rtr_out_arbiter.sv
// Round-robin arbiter that moves one FWFT packet at a time from the
// granted input FIFO into the shared router output FIFO. Each transfer
// takes IDLE -> XFER -> GAP, so at most one push is ever in flight.
module rtr_out_arbiter #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned pckg_sz = 40,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    rtr_out_arbiter_if.master           bus,
    output logic [$clog2(NUM_IN)-1:0]   grant_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            xfer_cnt,
    output logic [CNT_W-1:0]            stall_cnt
);
    localparam int unsigned IDW = $clog2(NUM_IN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [NUM_IN-1:0]    pop_q, pop_nx;
    logic                 push_q, push_nx;
    logic [pckg_sz-1:0]   data_q, data_nx;
    logic [IDW-1:0]       gid_q, gid_nx;
    logic [CNT_W-1:0]     xfer_q, xfer_nx;
    logic [CNT_W-1:0]     stall_q, stall_nx;

    logic [IDW-1:0]       win;
    logic                 found;
    logic [IDW-1:0]       cand;

    // Rotating priority search starting just after the last granted index
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            cand = IDW'((32'(gid_q) + 32'd1 + k) % NUM_IN);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic for the transfer sequencer
    always_comb begin
        state_nx = state;
        pop_nx   = '0;
        push_nx  = 1'b0;
        data_nx  = data_q;
        gid_nx   = gid_q;
        xfer_nx  = xfer_q;
        stall_nx = stall_q;
        case (state)
            IDLE: begin
                if (bus.en && found) begin
                    if (!bus.out_full) begin
                        state_nx     = XFER;
                        pop_nx[win]  = 1'b1;
                        push_nx      = 1'b1;
                        data_nx      = bus.data_in[32'(win) * pckg_sz +: pckg_sz];
                        gid_nx       = win;
                    end else if (stall_q != '1) begin
                        stall_nx = stall_q + 1'b1;
                    end
                end
            end
            XFER: begin
                xfer_nx  = xfer_q + 1'b1;
                state_nx = GAP;
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops any in-flight pop/push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pop_q   <= '0;
            push_q  <= 1'b0;
            data_q  <= '0;
            gid_q   <= IDW'(NUM_IN - 1);
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            state   <= state_nx;
            pop_q   <= pop_nx;
            push_q  <= push_nx;
            data_q  <= data_nx;
            gid_q   <= gid_nx;
            xfer_q  <= xfer_nx;
            stall_q <= stall_nx;
        end
    end

    assign bus.pop      = pop_q;
    assign bus.push     = push_q;
    assign bus.data_out = data_q;
    assign grant_id     = gid_q;
    assign busy         = (state != IDLE);
    assign xfer_cnt     = xfer_q;
    assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_rtr_out_arbiter.sv
// Directed bench for rtr_out_arbiter: a default-sized instance for the
// arbitration scenarios and a CNT_W=4 instance for counter wrap/saturation.
module tb_rtr_out_arbiter;
    logic clk;
    logic reset;

    logic [1:0]  grant_id, grant_id2;
    logic        busy, busy2;
    logic [15:0] xfer_cnt, stall_cnt;
    logic [3:0]  xfer_cnt2, stall_cnt2;

    int checks;
    int passes;

    rtr_out_arbiter_if #(.NUM_IN(4), .pckg_sz(40)) bus ();
    rtr_out_arbiter_if #(.NUM_IN(4), .pckg_sz(40)) bus2 ();

    rtr_out_arbiter #(.NUM_IN(4), .pckg_sz(40), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant_id(grant_id), .busy(busy), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
    );

    rtr_out_arbiter #(.NUM_IN(4), .pckg_sz(40), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .grant_id(grant_id2), .busy(busy2), .xfer_cnt(xfer_cnt2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_inputs();
        bus.en = 1'b1;  bus.req = '0;  bus.out_full = 1'b0;
        bus.data_in = {40'h0000001003, 40'h0000001002, 40'h0000001001, 40'h0000001000};
        bus2.en = 1'b1; bus2.req = '0; bus2.out_full = 1'b0;
        bus2.data_in = {40'h33, 40'h22, 40'h11, 40'h77};
    endtask

    task automatic do_reset();
        set_idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.pop !== 4'b0000 || bus.push !== 1'b0 || bus.data_out !== 40'h0)
            $display("FAIL reset_outputs: pop=%b push=%b data=%h want 0000/0/0",
                     bus.pop, bus.push, bus.data_out);
        else passes++;
        checks++;
        if (grant_id !== 2'd3 || busy !== 1'b0)
            $display("FAIL reset_state: grant_id=%0d busy=%b want 3/0", grant_id, busy);
        else passes++;
        checks++;
        if (xfer_cnt !== 16'd0 || stall_cnt !== 16'd0)
            $display("FAIL reset_counters: xfer=%0d stall=%0d want 0/0", xfer_cnt, stall_cnt);
        else passes++;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        bus.data_in[39:0] = 40'hA5;
        tick();
        checks++;
        if (bus.pop !== 4'b0001 || bus.push !== 1'b1 || bus.data_out !== 40'hA5 || grant_id !== 2'd0)
            $display("FAIL single_grant: pop=%b push=%b data=%h gid=%0d want 0001/1/a5/0",
                     bus.pop, bus.push, bus.data_out, grant_id);
        else passes++;
        checks++;
        if (busy !== 1'b1 || xfer_cnt !== 16'd0)
            $display("FAIL single_xfer_state: busy=%b xfer=%0d want 1/0", busy, xfer_cnt);
        else passes++;
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.pop !== 4'b0000 || bus.push !== 1'b0 || xfer_cnt !== 16'd1 || busy !== 1'b1)
            $display("FAIL single_gap: pop=%b push=%b xfer=%0d busy=%b want 0000/0/1/1",
                     bus.pop, bus.push, xfer_cnt, busy);
        else passes++;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.data_out !== 40'hA5)
            $display("FAIL single_idle: busy=%b data=%h want 0/a5", busy, bus.data_out);
        else passes++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  id;
        logic [3:0]  exp_pop;
        logic [39:0] exp_data;
        do_reset();
        bus.req = 4'b1111;
        for (int t = 1; t <= 13; t++) begin
            tick();
            checks++;
            if (!$onehot0(bus.pop) || bus.push !== (|bus.pop))
                $display("FAIL rr_invariant t=%0d: pop=%b push=%b", t, bus.pop, bus.push);
            else passes++;
            if (t % 3 == 1) begin
                id       = 2'((t - 1) / 3);
                exp_pop  = 4'b0001 << id;
                exp_data = 40'h1000 + 40'(id);
                checks++;
                if (bus.push !== 1'b1 || bus.pop !== exp_pop || grant_id !== id || bus.data_out !== exp_data)
                    $display("FAIL rr_grant t=%0d: pop=%b gid=%0d data=%h push=%b want %b/%0d/%h/1",
                             t, bus.pop, grant_id, bus.data_out, bus.push, exp_pop, id, exp_data);
                else passes++;
            end else begin
                checks++;
                if (bus.push !== 1'b0)
                    $display("FAIL rr_spacing t=%0d: push=%b want 0", t, bus.push);
                else passes++;
            end
        end
        checks++;
        if (xfer_cnt !== 16'd4)
            $display("FAIL rr_xfer_cnt: xfer=%0d want 4", xfer_cnt);
        else passes++;
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_out_full();
        do_reset();
        bus.req = 4'b0100;
        bus.out_full = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++;
            if (bus.push !== 1'b0 || bus.pop !== 4'b0000)
                $display("FAIL full_no_push t=%0d: push=%b pop=%b want 0/0000", t, bus.push, bus.pop);
            else passes++;
        end
        checks++;
        if (stall_cnt !== 16'd5)
            $display("FAIL full_stall_cnt: stall=%0d want 5", stall_cnt);
        else passes++;
        bus.out_full = 1'b0;
        tick();
        checks++;
        if (bus.pop !== 4'b0100 || bus.push !== 1'b1 || grant_id !== 2'd2 || stall_cnt !== 16'd5)
            $display("FAIL full_release: pop=%b push=%b gid=%0d stall=%0d want 0100/1/2/5",
                     bus.pop, bus.push, grant_id, stall_cnt);
        else passes++;
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (bus.pop !== 4'b0010 || xfer_cnt !== 16'd1)
            $display("FAIL midrst_setup: pop=%b xfer=%0d want 0010/1", bus.pop, xfer_cnt);
        else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pop !== 4'b0000 || bus.push !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_drop: pop=%b push=%b busy=%b want 0000/0/0", bus.pop, bus.push, busy);
        else passes++;
        checks++;
        if (xfer_cnt !== 16'd0 || stall_cnt !== 16'd0 || grant_id !== 2'd3)
            $display("FAIL midrst_state: xfer=%0d stall=%0d gid=%0d want 0/0/3",
                     xfer_cnt, stall_cnt, grant_id);
        else passes++;
        bus.req = 4'b0000;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_enable();
        do_reset();
        bus.en = 1'b0;
        bus.req = 4'b0011;
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++;
            if (bus.pop !== 4'b0000 || bus.push !== 1'b0)
                $display("FAIL en_block t=%0d: pop=%b push=%b want 0000/0", t, bus.pop, bus.push);
            else passes++;
        end
        checks++;
        if (stall_cnt !== 16'd0)
            $display("FAIL en_stall: stall=%0d want 0", stall_cnt);
        else passes++;
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.pop !== 4'b0001 || grant_id !== 2'd0 || bus.data_out !== 40'h1000)
            $display("FAIL en_grant: pop=%b gid=%0d data=%h want 0001/0/1000",
                     bus.pop, grant_id, bus.data_out);
        else passes++;
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_counter_limits();
        do_reset();
        bus2.req = 4'b0001;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (t == 47) begin
                checks++;
                if (xfer_cnt2 !== 4'd0)
                    $display("FAIL cnt_wrap16: xfer=%0d want 0", xfer_cnt2);
                else passes++;
            end
        end
        checks++;
        if (xfer_cnt2 !== 4'd1)
            $display("FAIL cnt_wrap17: xfer=%0d want 1", xfer_cnt2);
        else passes++;
        bus2.out_full = 1'b1;
        tick();
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 14) begin
                checks++;
                if (stall_cnt2 !== 4'd14)
                    $display("FAIL stall_count14: stall=%0d want 14", stall_cnt2);
                else passes++;
            end
        end
        checks++;
        if (stall_cnt2 !== 4'hF || bus2.push !== 1'b0 || xfer_cnt2 !== 4'd1)
            $display("FAIL stall_saturate: stall=%h push=%b xfer=%0d want f/0/1",
                     stall_cnt2, bus2.push, xfer_cnt2);
        else passes++;
        bus2.req = 4'b0000;
        bus2.out_full = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b0;
        set_idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_out_full();
        test_reset_mid_xfer();
        test_enable();
        test_counter_limits();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
